// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, divisor defaults and
// the round-robin winner search used by the TX scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_BUSY,
    ST_HOLD
  } sched_state_e;

  localparam int unsigned DEF_DIV    = 651;
  localparam int unsigned OVERSAMPLE = 16;

  // Returns {found, index}: the first set bit of valid at or after ptr,
  // wrapping modulo n. Supports up to 8 requesters; ptr must be below n.
  function automatic logic [3:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [3:0] res;
    logic [2:0] idx;
    int         sum;
    res = 4'd0;
    // Walk from the farthest offset down so the nearest hit is kept last.
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        sum = int'(ptr) + i;
        if (sum >= n) sum = sum - n;
        idx = 3'(sum);
        if (valid[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// 16x oversampling tick generator shared by the UART RX and TX cores.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_DIV
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_DIV_WE,
  input  logic [15:0] i_DIV,
  output logic        o_S_TICK
);

  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        tick;

  // Tick on the last count of the period; divisors 0 and 1 tick every cycle.
  // A divisor load restarts the period and suppresses the tick in that cycle.
  always_comb begin
    tick = 1'b0;
    if (!i_DIV_WE) tick = (div_q <= 16'd1) || (cnt_q == div_q - 16'd1);
    cnt_d = cnt_q + 16'd1;
    if (i_DIV_WE || tick) cnt_d = 16'd0;
  end

  // Divisor register and period counter.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      div_q <= 16'(TICK_DIV);
      cnt_q <= 16'd0;
    end else begin
      if (i_DIV_WE) div_q <= i_DIV;
      cnt_q <= cnt_d;
    end
  end

  assign o_S_TICK = tick & i_RST_n;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX core among N_REQ byte requesters with round-robin
// arbitration and packet locking; also hosts the oversampling tick.
//
// state | meaning
// IDLE  | no owner; accept first valid requester at/after rr_ptr
// SEND  | one-cycle start pulse to the TX core with the captured byte
// BUSY  | waiting for the TX core done pulse
// HOLD  | packet lock kept; only the owner may send, until hold timeout
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TICK_DIV   = DEF_DIV,
  parameter int unsigned HOLD_TICKS = 160
) (
  input  logic               i_CLK,
  input  logic               i_RST_n,
  input  logic [N_REQ-1:0]   i_REQ_VALID,
  input  logic [N_REQ-1:0]   i_REQ_LAST,
  input  logic [8*N_REQ-1:0] i_REQ_DATA,
  output logic [N_REQ-1:0]   o_REQ_READY,
  output logic [N_REQ-1:0]   o_GRANT,
  output logic               o_TX_START,
  output logic [7:0]         o_TX_DIN,
  input  logic               i_TX_DONE,
  input  logic               i_DIV_WE,
  input  logic [15:0]        i_DIV,
  output logic               o_S_TICK
);

  localparam int unsigned PTR_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_TICKS);

  sched_state_e      state_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  idx_q;
  logic [N_REQ-1:0]  grant_q;
  logic [7:0]        data_q;
  logic              last_q;
  logic              start_q;
  logic [HOLD_W-1:0] hold_q;

  logic              s_tick;
  logic [3:0]        pick;
  logic              pick_ok;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  sel_idx;
  logic [PTR_W-1:0]  rr_next;
  logic [7:0]        sel_byte;
  logic              sel_last;
  logic [N_REQ-1:0]  ready;
  logic [7:0]        req_byte [N_REQ];

  uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_CLK    (i_CLK),
    .i_RST_n  (i_RST_n),
    .i_DIV_WE (i_DIV_WE),
    .i_DIV    (i_DIV),
    .o_S_TICK (s_tick)
  );

  // Split the flat data bus into per-requester bytes.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) req_byte[k] = i_REQ_DATA[8*k +: 8];
  end

  // Winner search, transfer-cycle byte select and combinational ready.
  always_comb begin
    pick     = rr_pick(8'(i_REQ_VALID), 3'(rr_ptr_q), int'(N_REQ));
    pick_ok  = pick[3];
    pick_idx = PTR_W'(pick[2:0]);
    sel_idx  = (state_q == ST_IDLE) ? pick_idx : idx_q;
    sel_byte = req_byte[sel_idx];
    sel_last = i_REQ_LAST[sel_idx];
    rr_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    ready    = '0;
    if (state_q == ST_IDLE && pick_ok) ready[pick_idx] = 1'b1;
    else if (state_q == ST_HOLD && i_REQ_VALID[idx_q]) ready[idx_q] = 1'b1;
    // Ready is combinational, so mask it while reset is held.
    if (!i_RST_n) ready = '0;
  end

  // Scheduler FSM with registered grant, start and data outputs.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      data_q   <= 8'd0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      hold_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_ok) begin
            idx_q   <= pick_idx;
            grant_q <= N_REQ'(1) << pick_idx;
            data_q  <= sel_byte;
            last_q  <= sel_last;
            start_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: state_q <= ST_BUSY;
        ST_BUSY: begin
          if (i_TX_DONE) begin
            if (last_q) begin
              rr_ptr_q <= rr_next;
              grant_q  <= '0;
              state_q  <= ST_IDLE;
            end else begin
              hold_q  <= '0;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // A waiting owner byte takes precedence over a same-cycle timeout.
          if (i_REQ_VALID[idx_q]) begin
            data_q  <= sel_byte;
            last_q  <= sel_last;
            start_q <= 1'b1;
            state_q <= ST_SEND;
          end else if (s_tick) begin
            if (hold_q + 1'b1 == HOLD_LIM) begin
              rr_ptr_q <= rr_next;
              grant_q  <= '0;
              state_q  <= ST_IDLE;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_REQ_READY = ready;
  assign o_GRANT     = grant_q;
  assign o_TX_START  = start_q;
  assign o_TX_DIN    = data_q;
  assign o_S_TICK    = s_tick;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester queues, a TX core model and a
// scoreboard that checks every start against the expected owner and byte.
module tb_uart_tx_sched;

  localparam int N        = 4;
  localparam int CORE_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid, last;
  logic [8*N-1:0] data;
  logic [N-1:0]  ready, grant;
  logic          start;
  logic [7:0]    din;
  logic          done;
  logic          div_we;
  logic [15:0]   div;
  logic          tick;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(.N_REQ(N), .TICK_DIV(3), .HOLD_TICKS(4)) dut (
    .i_CLK       (clk),
    .i_RST_n     (rst_n),
    .i_REQ_VALID (valid),
    .i_REQ_LAST  (last),
    .i_REQ_DATA  (data),
    .o_REQ_READY (ready),
    .o_GRANT     (grant),
    .o_TX_START  (start),
    .o_TX_DIN    (din),
    .i_TX_DONE   (done),
    .i_DIV_WE    (div_we),
    .i_DIV       (div),
    .o_S_TICK    (tick)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  rq [N][$];   // {last, byte} per requester
  logic [11:0] exp_q [$];   // {grant one-hot, byte}
  int          starts = 0;
  int          done_cyc = -100;
  bit          chk_gap = 1'b0;
  logic [N-1:0] xfer = '0;
  bit          start_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, required event not seen (cycle %0d)", name, cyc);
  endtask

  // Requesters present the head of their queue; a transfer pops it.
  initial begin
    valid = '0; last = '0; data = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++)
        if (xfer[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      for (int k = 0; k < N; k++) begin
        if (rq[k].size() > 0) begin
          valid[k] = 1'b1;
          last[k]  = rq[k][0][8];
          data[8*k +: 8] = rq[k][0][7:0];
        end else begin
          valid[k] = 1'b0;
          last[k]  = 1'b0;
          data[8*k +: 8] = 8'h00;
        end
      end
    end
  end

  // TX core model: done pulse CORE_LAT+1 cycles after a start, aborted by reset.
  initial begin
    int cnt;
    cnt = 0;
    done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = 0;
        done = 1'b0;
      end else if (done) begin
        done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          done_cyc = cyc;
        end
      end else if (start_seen) begin
        cnt = CORE_LAT;
      end
    end
  end

  // Monitor: handshake sanity and scoreboard compare on every start.
  always @(negedge clk) begin
    logic [11:0] e;
    xfer = ready & valid;
    start_seen = start;
    if (rst_n) begin
      if (ready != '0)
        check("ready_onehot_valid", {31'b0, ($onehot(ready) && ((ready & ~valid) == '0))}, 32'd1);
      if (start) begin
        starts++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got grant %b din %h, required no start", grant, din);
        end else begin
          e = exp_q.pop_front();
          check("start_grant_din", {20'b0, grant, din}, {20'b0, e});
        end
        if (chk_gap) check("start_after_done_gap", cyc - done_cyc, 32'd2);
      end
    end
  end

  task automatic wait_starts(input int target);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (starts >= target) return;
    end
    fail_timeout("wait_start");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        repeat (10) @(posedge clk);
        return;
      end
    end
    fail_timeout("scoreboard_drain");
    exp_q.delete();
  endtask

  task automatic wait_tick(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) begin
        c = cyc;
        return;
      end
    end
    fail_timeout("wait_tick");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    fail_timeout("wait_done");
  endtask

  initial begin
    int c0, c1, n;
    bit seen;
    logic [1:0] order [4];
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
    div_we = 1'b0;
    div = 16'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_grant", {28'b0, grant}, 32'd0);
    check("rst_ready", {28'b0, ready}, 32'd0);
    check("rst_start", {31'b0, start}, 32'd0);
    check("rst_din", {24'b0, din}, 32'd0);
    check("rst_tick", {31'b0, tick}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tick divisor: reset value 3, load 5 on a would-be tick cycle, then 0
    wait_tick(c0);
    wait_tick(c1);
    check("tick_period_3", c1 - c0, 32'd3);
    wait_tick(c0);
    check("tick_period_3b", c0 - c1, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    div_we = 1'b1; div = 16'd5;
    @(negedge clk);
    check("tick_load_suppressed", {31'b0, tick}, 32'd0);
    @(posedge clk); #1;
    div_we = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("tick_after_load5", {31'b0, tick}, {31'b0, (j == 5)});
    end
    @(posedge clk); #1;
    div_we = 1'b1; div = 16'd0;
    @(negedge clk);
    check("tick_load0_suppressed", {31'b0, tick}, 32'd0);
    @(posedge clk); #1;
    div_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("tick_div0_every_cycle", {31'b0, tick}, 32'd1);
    end
    @(posedge clk); #1;
    div_we = 1'b1; div = 16'd3;
    @(posedge clk); #1;
    div_we = 1'b0;

    // Single byte from req0
    @(negedge clk);
    rq[0].push_back({1'b1, 8'hA5});
    exp_q.push_back({4'b0001, 8'hA5});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (valid[0]) seen = 1'b1;
    end
    if (!seen) fail_timeout("single_valid");
    check("single_ready_same_cycle", {28'b0, ready}, 32'h1);
    @(negedge clk);
    check("single_start", {31'b0, start}, 32'd1);
    check("single_grant", {28'b0, grant}, 32'h1);
    check("single_din", {24'b0, din}, 32'hA5);
    @(negedge clk);
    check("single_start_one_cycle", {31'b0, start}, 32'd0);
    wait_done();
    @(negedge clk);
    check("single_grant_cleared", {28'b0, grant}, 32'd0);
    wait_drain();

    // Round robin: rr_ptr is 1 after req0 finished, so order 1,2,3,0,1,2,3,0
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        rq[k].push_back({1'b1, 8'(8'h40 + 16 * r + k)});
    for (int r = 0; r < 2; r++)
      for (int o = 0; o < 4; o++)
        exp_q.push_back({4'(1 << order[o]), 8'(8'h40 + 16 * r + order[o])});
    wait_starts(starts + 1);
    chk_gap = 1'b1;
    wait_drain();
    chk_gap = 1'b0;

    // Packet lock: req1 sends 3 bytes before req2 (rr_ptr is 1)
    @(negedge clk);
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33});
    rq[2].push_back({1'b1, 8'h44});
    exp_q.push_back({4'b0010, 8'h11});
    exp_q.push_back({4'b0010, 8'h22});
    exp_q.push_back({4'b0010, 8'h33});
    exp_q.push_back({4'b0100, 8'h44});
    wait_starts(starts + 1);
    chk_gap = 1'b1;
    wait_drain();
    chk_gap = 1'b0;

    // Reset mid-frame, then req0 beats req1 with rr_ptr back at 0
    @(negedge clk);
    rq[2].push_back({1'b1, 8'h99});
    exp_q.push_back({4'b0100, 8'h99});
    wait_starts(starts + 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_start", {31'b0, start}, 32'd0);
    check("midrst_din", {24'b0, din}, 32'd0);
    check("midrst_grant", {28'b0, grant}, 32'd0);
    rq[0].push_back({1'b1, 8'hB0});
    rq[1].push_back({1'b1, 8'hB1});
    exp_q.push_back({4'b0001, 8'hB0});
    exp_q.push_back({4'b0010, 8'hB1});
    repeat (3) @(negedge clk);
    check("midrst_ready_masked", {28'b0, ready}, 32'd0);
    check("midrst_tick", {31'b0, tick}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_req0_wins", {28'b0, ready}, 32'h1);
    wait_drain();

    // Hold timeout: req0 sends non-last byte then goes quiet; req3 waits
    @(negedge clk);
    rq[0].push_back({1'b0, 8'h5A});
    exp_q.push_back({4'b0001, 8'h5A});
    wait_starts(starts + 1);
    @(negedge clk);
    rq[3].push_back({1'b1, 8'h77});
    exp_q.push_back({4'b1000, 8'h77});
    wait_done();
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      check("hold_grant_locked", {28'b0, grant}, 32'h1);
      check("hold_no_ready", {28'b0, ready}, 32'd0);
      if (tick) n++;
    end
    if (n < 4) fail_timeout("hold_ticks");
    @(negedge clk);
    check("hold_timeout_grant_cleared", {28'b0, grant}, 32'd0);
    check("hold_timeout_req3_ready", {28'b0, ready}, 32'h8);
    wait_drain();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
